// File: rtl/reqrsp_to_mem.sv
// Terminating reqrsp responder: turns q-channel requests into SRAM/OBI-style memory
// accesses and returns in-order p-channel responses; AMOs are answered with an error.
package reqrsp_to_mem_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0, AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
        AMOMax, AMOMaxu, AMOMin, AMOMinu, AMOLR, AMOSC
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } reqrsp_q_t;

    typedef struct packed {
        logic      q_valid;
        reqrsp_q_t q;
        logic      p_ready;
    } reqrsp_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } reqrsp_p_t;

    typedef struct packed {
        logic      q_ready;
        logic      p_valid;
        reqrsp_p_t p;
    } reqrsp_rsp_t;
endpackage

module reqrsp_to_mem_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] store [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic [CntW-1:0]  cnt;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_i) wptr <= wrap_inc(wptr);
            if (pop_i)  rptr <= wrap_inc(rptr);
            if (push_i && !pop_i)      cnt <= cnt + CntW'(1);
            else if (!push_i && pop_i) cnt <= cnt - CntW'(1);
        end
    end

    // Payload needs no reset; only the pointers define occupancy.
    always_ff @(posedge clk_i) begin
        if (push_i) store[wptr] <= data_i;
    end

    assign data_o  = store[rptr];
    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == CntW'(Depth));
endmodule

module reqrsp_to_mem
    import reqrsp_to_mem_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter type         req_t          = reqrsp_req_t,
    parameter type         rsp_t          = reqrsp_rsp_t,
    parameter int unsigned NumOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  req_t                   req_i,
    output rsp_t                   rsp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);
    localparam int unsigned CntW    = $clog2(NumOutstanding + 1);
    localparam int unsigned SizeMax = $clog2(DataWidth / 8);

    logic [CntW-1:0]      outstanding, mem_pending;
    logic                 credit, is_amo, accept, p_valid, p_hs;
    logic                 meta_head, meta_empty, meta_full;
    logic                 data_push, data_pop, data_empty, data_full;
    logic [DataWidth-1:0] data_head;

    assign credit = (outstanding < CntW'(NumOutstanding));
    assign is_amo = (req_i.q.amo != AMONone);

    // mem_req_o is kept free of mem_gnt_i; only q_ready looks at the grant.
    assign mem_req_o   = req_i.q_valid && credit && !is_amo;
    assign mem_addr_o  = req_i.q.addr;
    assign mem_we_o    = req_i.q.write;
    assign mem_wdata_o = req_i.q.data;
    assign mem_be_o    = req_i.q.strb;

    assign accept    = req_i.q_valid && credit && (is_amo || mem_gnt_i);
    assign data_push = mem_rvalid_i && (mem_pending != '0);
    assign p_valid   = !meta_empty && (meta_head || !data_empty);
    assign p_hs      = p_valid && req_i.p_ready;
    assign data_pop  = p_hs && !meta_head;

    always_comb begin
        rsp_o         = '0;
        rsp_o.q_ready = accept;
        rsp_o.p_valid = p_valid;
        rsp_o.p.error = meta_head;
        rsp_o.p.data  = meta_head ? '0 : data_head;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
            mem_pending <= '0;
        end else begin
            // Credit returned by a p handshake only becomes usable next cycle.
            if (accept && !p_hs)      outstanding <= outstanding + CntW'(1);
            else if (!accept && p_hs) outstanding <= outstanding - CntW'(1);
            case ({accept && !is_amo, data_push})
                2'b10:   mem_pending <= mem_pending + CntW'(1);
                2'b01:   mem_pending <= mem_pending - CntW'(1);
                default: ;
            endcase
        end
    end

    reqrsp_to_mem_fifo #(.Width(1), .Depth(NumOutstanding)) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (is_amo),
        .pop_i   (p_hs),
        .data_o  (meta_head),
        .empty_o (meta_empty),
        .full_o  (meta_full)
    );

    reqrsp_to_mem_fifo #(.Width(DataWidth), .Depth(NumOutstanding)) i_data_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (data_push),
        .data_i  (mem_rdata_i),
        .pop_i   (data_pop),
        .data_o  (data_head),
        .empty_o (data_empty),
        .full_o  (data_full)
    );

    a_data_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(data_push && data_full));
    a_meta_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(accept && meta_full));
    a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        req_i.q_valid |-> (32'(req_i.q.size) <= SizeMax));
    a_p_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_o.p_valid && !req_i.p_ready) |=> (rsp_o.p_valid && $stable(rsp_o.p)));
endmodule

// File: tb/tb_reqrsp_to_mem.sv
// Scoreboard bench for reqrsp_to_mem: directed requests push expected responses,
// a monitor pops and compares on every p handshake; a behavioural memory answers grants.
module tb_reqrsp_to_mem;
    import reqrsp_to_mem_pkg::*;

    logic        clk, rst;
    reqrsp_req_t req;
    reqrsp_rsp_t rsp;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int xfers  = 0;

    typedef struct { logic chk; logic [31:0] data; logic err; } exp_t;
    typedef struct { int due; logic [31:0] data; } ret_t;
    exp_t        exp_q[$];
    ret_t        ret_q[$];
    int          hs_log[$];
    logic [31:0] mem [logic [31:0]];
    int          rsp_n = 0;

    int          cap_cyc;
    logic        cap_req, cap_we;
    logic [31:0] cap_addr;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    reqrsp_to_mem #(
        .AddrWidth(32), .DataWidth(32),
        .req_t(reqrsp_req_t), .rsp_t(reqrsp_rsp_t), .NumOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .rsp_o(rsp),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    // Memory model: transfer on req && gnt, answer lat cycles later in order.
    always @(negedge clk) begin : mem_model
        logic [31:0] d;
        if (!rst && mem_req && mem_gnt) begin
            xfers++;
            d = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) d[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] = d;
            end
            ret_q.push_back('{due: cyc + lat, data: d});
        end
    end

    initial begin
        mem_rvalid = 0;
        mem_rdata  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                mem_rvalid = 1;
                mem_rdata  = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                mem_rvalid = 0;
                mem_rdata  = 32'h0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rsp.p_valid && req.p_ready) begin
            hs_log.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got data=%h err=%b", rsp.p.data, rsp.p.error);
            end else begin
                e = exp_q.pop_front();
                if (rsp.p.error !== e.err || (e.chk && rsp.p.data !== e.data)) begin
                    errors++;
                    $display("FAIL rsp_%0d got data=%h err=%b want data=%h err=%b",
                             rsp_n, rsp.p.data, rsp.p.error, e.data, e.err);
                end
            end
            rsp_n++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic c, input logic [31:0] d, input logic e);
        exp_q.push_back('{chk: c, data: d, err: e});
    endtask

    // Called at posedge+1 with q_valid already high; returns at posedge+1 after accept.
    task automatic wait_accept();
        logic got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp.q_ready) begin
                got = 1;
                cap_cyc = cyc; cap_req = mem_req; cap_addr = mem_addr; cap_we = mem_we;
            end
            @(posedge clk);
            #1;
        end
        req.q_valid = 0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%h never accepted", req.q.addr);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input amo_op_e op,
                         input logic [31:0] d, input logic [3:0] s);
        req.q.addr = a; req.q.write = w; req.q.amo = op;
        req.q.data = d; req.q.strb = s; req.q_valid = 1;
        wait_accept();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   c0, x0, bad;
        rst = 1;
        req = '0;
        req.q.size = 3'd2;
        mem_gnt = 1;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'h11111111;
        mem[32'h204] = 32'h22222222;
        mem[32'h208] = 32'h33333333;
        mem[32'hA0]  = 32'hA5A5A5A5;
        mem[32'h300] = 32'h30303030;
        mem[32'h304] = 32'h30403040;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q_ready", rsp.q_ready, 0);
        chk("rst_p_valid", rsp.p_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("idle_q_ready", rsp.q_ready, 0);
        chk("idle_mem_req", mem_req, 0);
        @(posedge clk);
        #1;

        // Single read, L = 1
        req.p_ready = 1;
        lat = 1;
        push_exp(1, 32'hDEADBEEF, 0);
        issue(32'h100, 0, AMONone, 32'h0, 4'hF);
        chk("t1_mem_req", cap_req, 1);
        chk("t1_addr", cap_addr, 32'h100);
        chk("t1_we", cap_we, 0);
        @(negedge clk);
        chk("t1_pv_early", rsp.p_valid, 0);
        @(negedge clk);
        chk("t1_pv_lat2", rsp.p_valid, 1);
        @(posedge clk);
        #1;
        wait_drain("t1");

        // Write then read back
        push_exp(0, 32'h0, 0);
        issue(32'h40, 1, AMONone, 32'h12345678, 4'hF);
        chk("t2_we", cap_we, 1);
        push_exp(1, 32'h12345678, 0);
        issue(32'h40, 0, AMONone, 32'h0, 4'hF);
        wait_drain("t2");

        // Backpressure: third read must wait for a freed credit
        req.p_ready = 0;
        push_exp(1, 32'h11111111, 0);
        issue(32'h200, 0, AMONone, 32'h0, 4'hF);
        push_exp(1, 32'h22222222, 0);
        issue(32'h204, 0, AMONone, 32'h0, 4'hF);
        push_exp(1, 32'h33333333, 0);
        req.q.addr = 32'h208; req.q.write = 0; req.q.amo = AMONone; req.q_valid = 1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp.q_ready || mem_req) bad++;
            @(posedge clk);
            #1;
        end
        chk("t3_full_blocks", bad, 0);
        hs_log.delete();
        req.p_ready = 1;
        wait_accept();
        chk("t3_no_bypass", (hs_log.size() > 0) && (cap_cyc > hs_log[0]), 1);
        wait_drain("t3");

        // AMO behind a slow read
        lat = 3;
        x0 = xfers;
        push_exp(1, 32'hA5A5A5A5, 0);
        issue(32'hA0, 0, AMONone, 32'h0, 4'hF);
        push_exp(1, 32'h0, 1);
        issue(32'hB0, 0, AMOAdd, 32'h1, 4'hF);
        chk("t4_amo_no_req", cap_req, 0);
        wait_drain("t4");
        chk("t4_xfers", xfers - x0, 1);

        // Lone AMO answers one cycle after accept
        lat = 1;
        push_exp(1, 32'h0, 1);
        issue(32'hC0, 1, AMOSwap, 32'h5, 4'hF);
        @(negedge clk);
        chk("t4b_err_lat1", rsp.p_valid && rsp.p.error, 1);
        @(posedge clk);
        #1;
        wait_drain("t4b");

        // Grant stall with a partial-strobe write
        mem_gnt = 0;
        req.q.addr = 32'h80; req.q.write = 1; req.q.amo = AMONone;
        req.q.data = 32'hCAFEF00D; req.q.strb = 4'h3; req.q_valid = 1;
        push_exp(0, 32'h0, 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (!mem_req || rsp.q_ready || mem_addr !== 32'h80 || mem_we !== 1'b1 ||
                mem_wdata !== 32'hCAFEF00D || mem_be !== 4'h3) bad++;
            @(posedge clk);
            #1;
        end
        chk("t5_stall", bad, 0);
        mem_gnt = 1;
        c0 = cyc;
        wait_accept();
        chk("t5_acc_cycle", cap_cyc, c0);
        push_exp(1, 32'h0000F00D, 0);
        issue(32'h80, 0, AMONone, 32'h0, 4'hF);
        wait_drain("t5");

        // Reset with two reads in flight; their late returns must be ignored
        lat = 6;
        issue(32'h300, 0, AMONone, 32'h0, 4'hF);
        issue(32'h304, 0, AMONone, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1;
        exp_q.delete();
        #1;
        chk("t6_pv_rst", rsp.p_valid, 0);
        chk("t6_outst_rst", dut.outstanding, 0);
        chk("t6_pend_rst", dut.mem_pending, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp.p_valid) bad++;
            @(posedge clk);
            #1;
        end
        chk("t6_no_pv", bad, 0);
        chk("t6_stale_gone", ret_q.size(), 0);
        chk("t6_pend_after", dut.mem_pending, 0);
        lat = 1;
        push_exp(1, 32'hDEADBEEF, 0);
        issue(32'h100, 0, AMONone, 32'h0, 4'hF);
        wait_drain("t6");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
